imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory fetch port.
- Accepts a byte stream over a valid/ready handshake, e.g. from a UART receiver or testbench driver.
- Assembles bytes big-endian into 32-bit instruction words and writes them into sequential IMEM word locations, starting at word 0.
- Holds the pipeline in stall until the image is loaded, so the CPU fetches from PC 0 only after loading completes.

---
 rtl/imem_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams a big-endian byte image into IMEM and holds the CPU until the load is done.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [31:0] DEPTH_C = 32'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                accept_s;
    logic [CNT_W-1:0]    count_full_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    assign accept_s     = in_valid && ready_q;
    // Header is two bytes, high byte first.
    assign count_full_s = {count_q[CNT_W-1:8], in_data};

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_HDR0;
                    idx_d   = '0;
                    bcnt_d  = 2'd0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_HDR0: begin
                if (accept_s) begin
                    count_d = {in_data, count_q[CNT_W-9:0]};
                    state_d = S_HDR1;
                end else begin
                    state_d = S_HDR0;
                end
            end
            S_HDR1: begin
                if (accept_s) begin
                    count_d = count_full_s;
                    if (count_full_s == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else if (32'(count_full_s) > DEPTH_C) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_HDR1;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    word_d = {word_q[15:0], in_data};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_update(csum_q, in_data);
`endif
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        wdata_d = {word_q, in_data};
                        addr_d  = idx_q[ADDR_W-1:0];
                        we_d    = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + CNT_W'(1);
                if (idx_q + CNT_W'(1) == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (in_data == csum_q) begin
                        error_d = 1'b0;
                        hold_d  = 1'b0;
                    end else begin
                        // Bad image: keep the CPU stalled.
                        error_d = 1'b1;
                        hold_d  = 1'b1;
                    end
                end else begin
                    state_d = S_CSUM;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // in_ready follows the state being entered so it is itself a register.
    always_comb begin
        ready_d = 1'b0;
        case (state_d)
            S_HDR0, S_HDR1, S_DATA, S_CSUM: ready_d = 1'b1;
            default:                        ready_d = 1'b0;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            bcnt_q  <= 2'd0;
            word_q  <= 24'd0;
            wdata_q <= 32'd0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images plus random images checked
// against a byte-list reference model of the load protocol.
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int nassert = 0;
    int nfail   = 0;
    logic [ADDR_W+31:0] wr_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Capture every write; in_ready must be low during a write cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_q.push_back({imem_addr, imem_wdata});
            chk("ready_in_write", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: alternate idle cycle, 2: random gaps
    task automatic send_byte(input logic [7:0] b, input int mode);
        int guard;
        int gap;
        guard = 0;
        gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int g = 0; g < gap; g++) step();
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"},    {31'd0, imem_we},  32'd0);
        chk({tag, "_addr"},  32'(imem_addr),    32'd0);
        chk({tag, "_wdata"}, imem_wdata,        32'd0);
        chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
        chk({tag, "_done"},  {31'd0, done},     32'd0);
        chk({tag, "_error"}, {31'd0, error},    32'd0);
    endtask

    // Load one image and compare writes and final flags with the model.
    task automatic run_load(input string tag, input bq_t img, input int mode, input bit bad_csum);
        int cnt;
        int guard;
        bit oversize;
        logic [7:0] x;
        logic [ADDR_W+31:0] exp_wr[$];
        cnt = (int'(img[0]) << 8) | int'(img[1]);
        oversize = (cnt > DEPTH);
        x = 8'h00;
        if (!oversize) begin
            for (int i = 0; i < cnt; i++) begin
                exp_wr.push_back({ADDR_W'(i), img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]});
                for (int k = 0; k < 4; k++) x = x ^ img[2+4*i+k];
            end
        end
        wr_q.delete();
        pulse_start();
        chk({tag, "_hold_at_start"}, {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < (oversize ? 2 : 2 + 4*cnt); i++) send_byte(img[i], mode);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!oversize) send_byte(x ^ (bad_csum ? 8'h01 : 8'h00), mode);
`else
        if (!oversize && cnt > 0) begin
            chk({tag, "_we_latency"}, {31'd0, imem_we}, 32'd1);
            step();
            chk({tag, "_done_latency"}, {31'd0, done}, 32'd1);
            chk({tag, "_hold_latency"}, {31'd0, cpu_hold}, 32'd0);
        end
`endif
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk({tag, "_error"}, {31'd0, error}, {31'd0, oversize | (!oversize & bad_csum)});
        chk({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !oversize & bad_csum});
`else
        chk({tag, "_error"}, {31'd0, error}, {31'd0, oversize});
        chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
`endif
        step();
        chk({tag, "_nwrites"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
            chk({tag, "_waddr"}, 32'(wr_q[i][ADDR_W+31:32]), 32'(exp_wr[i][ADDR_W+31:32]));
            chk({tag, "_wdata"}, wr_q[i][31:0], exp_wr[i][31:0]);
        end
    endtask

    initial begin
        bq_t img;
        bq_t basic;
        int cnt;
        basic = '{8'h00, 8'h02, 8'h01, 8'h09, 8'h50, 8'h20, 8'hAC, 8'h0A, 8'h00, 8'h00};

        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();
        chk("idle_hold", {31'd0, cpu_hold}, 32'd1);

        run_load("basic", basic, 0, 1'b0);
        run_load("throttled", basic, 1, 1'b0);
        img = '{8'h00, 8'h00};
        run_load("zero", img, 0, 1'b0);
        img = '{8'h04, 8'h01};
        run_load("oversize", img, 0, 1'b0);

        // Reset after 6 bytes: only the first word may have been written.
        wr_q.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(basic[i], 0);
        step();
        reset = 1'b1;
        step();
        check_reset_outputs("midreset");
        chk("midreset_nwrites", wr_q.size(), 32'd1);
        if (wr_q.size() > 0) chk("midreset_w0", wr_q[0][31:0], 32'h01095020);
        reset = 1'b0;
        repeat (3) step();
        chk("midreset_quiet", wr_q.size(), 32'd1);
        run_load("reload", basic, 0, 1'b0);

        // start outside IDLE/DONE must not restart the session.
        pulse_start();
        send_byte(8'h00, 0);
        pulse_start();
        send_byte(8'h01, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 0);
        repeat (2) step();
        chk("ignored_start_done", {31'd0, done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load("csum_ok", img, 0, 1'b0);
        run_load("csum_bad", img, 0, 1'b1);
`endif

        for (int r = 0; r < 6; r++) begin
            img.delete();
            cnt = (r == 5) ? int'($urandom_range(1025, 65535)) : int'($urandom_range(1, 8));
            img.push_back(8'(cnt >> 8));
            img.push_back(8'(cnt));
            if (cnt <= DEPTH)
                for (int i = 0; i < 4*cnt; i++) img.push_back(8'($urandom));
            run_load("random", img, 2, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
